// File: rtl/ram_capture_ctrl_pkg.sv
// Shared definitions for the capture controller and the RAM placed beside it:
// default geometry of the capture buffer and the controller state encoding.
package ram_capture_ctrl_pkg;

  localparam int unsigned DEF_RAM_WIDTH = 22;
  localparam int unsigned DEF_RAM_DEPTH = 1024;
  localparam int unsigned DEF_ADDR_SIZE = 11;
  localparam int unsigned DEF_SAMPLE_W  = 14;
  localparam int unsigned DEF_TAG_W     = DEF_RAM_WIDTH - DEF_SAMPLE_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_FULL    = 2'd2,
    S_READ    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/ram_capture_ctrl.sv
// Single-shot capture buffer controller. Once armed it writes tagged samples
// into an external RAM until RAM_DEPTH words are stored, holds them until the
// consumer starts reading, then streams them back out in address order.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   arm                 start a capture from IDLE
//   s_valid/s_sample/s_tag  sample strobe, value and tag
//   rd_req              consumer request for the next stored word
//   ram_wr_enb/ram_rd_enb/ram_addr/ram_data_in  RAM control (combinational)
//   ram_data_out        RAM read data, one cycle after ram_rd_enb
//   rd_valid/rd_data    word returned to the consumer
//   busy                capturing or reading
//   full                buffer holds a complete, unread capture
module ram_capture_ctrl
  import ram_capture_ctrl_pkg::*;
#(
  parameter int unsigned RAM_WIDTH = DEF_RAM_WIDTH,
  parameter int unsigned RAM_DEPTH = DEF_RAM_DEPTH,
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int unsigned SAMPLE_W  = DEF_SAMPLE_W,
  localparam int unsigned TAG_W    = RAM_WIDTH - SAMPLE_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 s_valid,
  input  logic [SAMPLE_W-1:0]  s_sample,
  input  logic [TAG_W-1:0]     s_tag,
  input  logic                 rd_req,
  output logic                 ram_wr_enb,
  output logic                 ram_rd_enb,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0] ram_data_in,
  input  logic [RAM_WIDTH-1:0] ram_data_out,
  output logic                 rd_valid,
  output logic [RAM_WIDTH-1:0] rd_data,
  output logic                 busy,
  output logic                 full
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(RAM_DEPTH - 1);

  cap_state_e           state, state_nxt;
  logic [ADDR_SIZE-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_SIZE-1:0] rd_ptr, rd_ptr_nxt;
  logic [RAM_WIDTH-1:0] rd_data_q;

  // State, pointers and the read-return pipeline stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_valid  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      rd_valid <= ram_rd_enb;
      if (rd_valid) begin
        rd_data_q <= ram_data_out;
      end
    end
  end

  // RAM data is only available in the return cycle, so pass it straight
  // through then and keep the captured copy during gaps.
  assign rd_data = rd_valid ? ram_data_out : rd_data_q;

  // Next state, pointer updates and RAM strobes
  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    ram_wr_enb  = 1'b0;
    ram_rd_enb  = 1'b0;
    ram_addr    = '0;
    ram_data_in = '0;
    busy        = 1'b0;
    full        = 1'b0;

    case (state)
      S_IDLE: begin
        if (arm) begin
          state_nxt  = S_CAPTURE;
          wr_ptr_nxt = '0;
        end
      end

      S_CAPTURE: begin
        busy = 1'b1;
        if (s_valid) begin
          ram_wr_enb  = 1'b1;
          ram_addr    = wr_ptr;
          ram_data_in = {s_tag, s_sample};
          // Pointer parks on the last address; no wrap, no overwrite
          if (wr_ptr == LAST_ADDR) begin
            state_nxt = S_FULL;
          end else begin
            wr_ptr_nxt = wr_ptr + ADDR_SIZE'(1);
          end
        end
      end

      S_FULL: begin
        full = 1'b1;
        if (rd_req) begin
          state_nxt  = S_READ;
          rd_ptr_nxt = '0;
        end
      end

      S_READ: begin
        busy = 1'b1;
        if (rd_req) begin
          ram_rd_enb = 1'b1;
          ram_addr   = rd_ptr;
          if (rd_ptr == LAST_ADDR) begin
            state_nxt = S_IDLE;
          end else begin
            rd_ptr_nxt = rd_ptr + ADDR_SIZE'(1);
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_capture_ctrl.sv
// Bench for ram_capture_ctrl: RAM model beside the DUT, a behavioural
// reference kept as counters plus a memory image, and per-cycle comparison.
module tb_ram_capture_ctrl;

  localparam int DEPTH = 1024;
  localparam int BOUND = 6000;

  localparam int P_IDLE = 0;
  localparam int P_CAP  = 1;
  localparam int P_FULL = 2;
  localparam int P_READ = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm;
  logic        s_valid;
  logic [13:0] s_sample;
  logic [7:0]  s_tag;
  logic        rd_req;
  logic        ram_wr_enb;
  logic        ram_rd_enb;
  logic [10:0] ram_addr;
  logic [21:0] ram_data_in;
  logic [21:0] ram_data_out;
  logic        rd_valid;
  logic [21:0] rd_data;
  logic        busy;
  logic        full;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_capture_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .s_valid      (s_valid),
    .s_sample     (s_sample),
    .s_tag        (s_tag),
    .rd_req       (rd_req),
    .ram_wr_enb   (ram_wr_enb),
    .ram_rd_enb   (ram_rd_enb),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .busy         (busy),
    .full         (full)
  );

  // Synchronous RAM beside the controller
  logic [21:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_enb) ram[ram_addr[9:0]] <= ram_data_in;
    if (ram_rd_enb) ram_data_out <= ram[ram_addr[9:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s cycle bound expired at t=%0t", nm, $time);
  endtask

  // Reference: phase, words written/read so far, memory image, return pipe
  int          ph = P_IDLE;
  int          nw = 0;
  int          nr = 0;
  logic        exp_rv = 1'b0;
  logic [21:0] exp_rd = '0;
  logic [21:0] mimg [DEPTH];
  bit          started = 1'b0;

  always @(posedge clk) if (!rst_n) started <= 1'b1;

  always @(negedge clk) begin : model
    logic        e_wr;
    logic        e_rd;
    logic [10:0] e_addr;
    logic [21:0] e_din;
    if (started) begin
      e_wr   = (ph == P_CAP)  && s_valid;
      e_rd   = (ph == P_READ) && rd_req;
      e_addr = e_wr ? 11'(nw) : (e_rd ? 11'(nr) : 11'd0);
      e_din  = e_wr ? {s_tag, s_sample} : 22'd0;

      chk("wr_enb",   32'(ram_wr_enb),  32'(e_wr));
      chk("rd_enb",   32'(ram_rd_enb),  32'(e_rd));
      chk("addr",     32'(ram_addr),    32'(e_addr));
      chk("data_in",  32'(ram_data_in), 32'(e_din));
      chk("busy",     32'(busy),        32'((ph == P_CAP) || (ph == P_READ)));
      chk("full",     32'(full),        32'(ph == P_FULL));
      chk("rd_valid", 32'(rd_valid),    32'(exp_rv));
      chk("rd_data",  32'(rd_data),     32'(exp_rd));
      chk("enb_excl", 32'(ram_wr_enb & ram_rd_enb), 32'd0);

      // Advance to the state after the coming rising edge
      if (e_wr) mimg[nw] = e_din;
      if (!rst_n) begin
        ph = P_IDLE; nw = 0; nr = 0; exp_rv = 1'b0; exp_rd = '0;
      end else begin
        exp_rv = e_rd;
        if (e_rd) exp_rd = mimg[nr];
        case (ph)
          P_IDLE: if (arm) begin ph = P_CAP; nw = 0; end
          P_CAP:  if (s_valid) begin
                    if (nw == DEPTH - 1) ph = P_FULL; else nw++;
                  end
          P_FULL: if (rd_req) begin ph = P_READ; nr = 0; end
          default: if (rd_req) begin
                    if (nr == DEPTH - 1) ph = P_IDLE; else nr++;
                  end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] lit;
    int          cyc;
    bit          pulsed;
    bit          rdone;

    arm = 0; s_valid = 0; s_sample = '0; s_tag = '0; rd_req = 0; rst_n = 0;
    repeat (3) tick();
    rst_n = 1;
    #1;
    chk("rst_busy",     32'(busy),       32'd0);
    chk("rst_full",     32'(full),       32'd0);
    chk("rst_rd_valid", 32'(rd_valid),   32'd0);
    chk("rst_rd_data",  32'(rd_data),    32'd0);
    chk("rst_addr",     32'(ram_addr),   32'd0);
    tick();

    // Contiguous capture of sample n / tag n[7:0]
    arm = 1; tick(); arm = 0;
    for (int n = 0; n < DEPTH; n++) begin
      s_valid = 1; s_sample = 14'(n); s_tag = 8'(n);
      #1;
      if (n == 5) begin
        lit = {8'd5, 14'd5};
        chk("lit_wr5_addr", 32'(ram_addr),    32'd5);
        chk("lit_wr5_data", 32'(ram_data_in), 32'(lit));
      end
      tick();
    end
    s_valid = 0;
    #1;
    chk("lit_full_after_1024", 32'(full), 32'd1);
    chk("lit_busy_after_1024", 32'(busy), 32'd0);
    tick();

    // Read-out with rd_req held high
    rd_req = 1; tick();
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      if (k == 4) begin
        lit = {8'd3, 14'd3};
        chk("lit_rd3_valid", 32'(rd_valid), 32'd1);
        chk("lit_rd3_data",  32'(rd_data),  32'(lit));
      end
      tick();
    end
    rd_req = 0;
    #1;
    lit = {8'hff, 14'd1023};
    chk("lit_last_valid", 32'(rd_valid), 32'd1);
    chk("lit_last_data",  32'(rd_data),  32'(lit));
    chk("lit_last_idle",  32'(busy | full), 32'd0);
    tick();

    // Gapped capture with a stray arm at pointer 500
    arm = 1; tick(); arm = 0;
    cyc = 0; pulsed = 0;
    while (ph == P_CAP && cyc < BOUND) begin
      s_valid  = (cyc % 3 == 0);
      arm      = (nw == 500 && !pulsed);
      if (arm) pulsed = 1;
      s_sample = 14'($urandom);
      s_tag    = 8'($urandom);
      tick();
      cyc++;
    end
    arm = 0;
    if (cyc >= BOUND) bound_fail("gapped_capture");
    // Samples offered while full must be dropped
    repeat (5) begin
      s_valid = 1; s_sample = 14'($urandom); s_tag = 8'($urandom);
      tick();
    end
    s_valid = 0;

    // Toggled reads, then reset on the read of address 10
    rd_req = 1; tick();
    cyc = 0;
    while (cyc < 200) begin
      rd_req = (cyc % 2 == 0);
      if (rd_req && nr == 10) break;
      tick();
      cyc++;
    end
    rst_n = 0; rd_req = 1;
    #1;
    chk("lit_rst_rd_enb",  32'(ram_rd_enb), 32'd1);
    chk("lit_rst_rd_addr", 32'(ram_addr),   32'd10);
    tick();
    rst_n = 1; rd_req = 0;
    #1;
    chk("lit_after_rst_valid", 32'(rd_valid), 32'd0);
    chk("lit_after_rst_data",  32'(rd_data),  32'd0);
    chk("lit_after_rst_state", 32'(busy | full), 32'd0);
    tick();

    // Randomized rounds
    for (int r = 0; r < 5; r++) begin
      rdone = 0;
      repeat ($urandom_range(0, 5)) begin
        s_valid = 1'($urandom); rd_req = 1'($urandom); tick();
      end
      cyc = 0;
      while (ph != P_FULL && cyc < BOUND) begin
        arm      = (ph == P_IDLE) ? 1'b1 : ($urandom_range(0, 15) == 0);
        s_valid  = ($urandom_range(0, 3) != 0);
        s_sample = 14'($urandom);
        s_tag    = 8'($urandom);
        rd_req   = 1'($urandom);
        rst_n    = 1;
        if (r == 2 && ph == P_CAP && nw == 300 && !rdone) begin
          rst_n = 0; rdone = 1;
        end
        tick();
        cyc++;
      end
      rst_n = 1; arm = 0; rd_req = 0;
      if (cyc >= BOUND) bound_fail("rand_capture");
      repeat ($urandom_range(1, 8)) begin
        s_valid = 1'($urandom); s_sample = 14'($urandom); tick();
      end
      cyc = 0;
      while (ph != P_IDLE && cyc < BOUND) begin
        rd_req  = ($urandom_range(0, 3) != 0);
        s_valid = 1'($urandom);
        arm     = ($urandom_range(0, 15) == 0);
        rst_n   = 1;
        if (r == 3 && ph == P_READ && nr == 700 && !rdone) begin
          rst_n = 0; rdone = 1;
        end
        tick();
        cyc++;
      end
      rst_n = 1; arm = 0; rd_req = 0; s_valid = 0;
      if (cyc >= BOUND) bound_fail("rand_read");
      tick();
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
